// File: rtl/pipeline_types.sv
// Shared pipeline type definitions.
// fq_entry_t   : one predecoded instruction as produced by fetch.
// FQ_DEPTH_DEFAULT : default number of fetch queue entries.
package pipeline_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        pre_taken;
        logic [31:0] pre_target;
        logic        is_exception;
        logic [6:0]  exception_cause;
    } fq_entry_t;

    localparam int FQ_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/fq_lane_compact.sv
// Lane compaction helper: for a sparse valid mask, gives each lane the
// number of valid lanes below it (its slot offset when packed densely)
// and the total number of valid lanes.
// Ports:
//   valid   in  WIDTH         per-lane valid, lane 0 oldest
//   offset  out WIDTH x CW    packed slot offset of each lane
//   n_valid out CW            popcount of valid
module fq_lane_compact #(
    parameter  int WIDTH = 2,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         valid,
    output logic [WIDTH-1:0][CW-1:0] offset,
    output logic [CW-1:0]            n_valid
);

    logic [CW-1:0] acc;

    // Running prefix sum: a lane's offset counts only lanes strictly below it.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        n_valid = acc;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-lane in-order instruction queue between fetch and decode.
// Sparse fetch lanes are compacted into a circular buffer; up to
// ISSUE_WIDTH oldest entries are presented to decode each cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      discard all contents (next cycle empty)
//   in_valid   per-lane fetch valid (may be sparse)
//   in_entry   fetch lane payloads, lane 0 oldest
//   in_ready   at least FETCH_WIDTH free slots
//   out_valid  contiguous prefix mask of presented entries
//   out_entry  oldest entries, lane 0 oldest
//   out_pop    number of presented entries consumed this cycle
//   count      current occupancy
module inst_fetch_queue
    import pipeline_types::*;
#(
    parameter  int FETCH_WIDTH = 2,
    parameter  int ISSUE_WIDTH = 2,
    parameter  int DEPTH       = FQ_DEPTH_DEFAULT,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int OW          = $clog2(ISSUE_WIDTH + 1),
    localparam int FCW         = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic      [FETCH_WIDTH-1:0]       in_valid,
    input  fq_entry_t [FETCH_WIDTH-1:0]       in_entry,
    output logic                              in_ready,
    output logic      [ISSUE_WIDTH-1:0]       out_valid,
    output fq_entry_t [ISSUE_WIDTH-1:0]       out_entry,
    input  logic      [OW-1:0]                out_pop,
    output logic      [CW-1:0]                count
);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * FETCH_WIDTH || DEPTH < 2 * ISSUE_WIDTH) begin : g_bad_depth
        $error("inst_fetch_queue: DEPTH must be a power of two >= 2*max(FETCH_WIDTH, ISSUE_WIDTH)");
    end

    fq_entry_t mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic [FETCH_WIDTH-1:0][FCW-1:0] lane_off;
    logic [FCW-1:0]                  lane_cnt;
    logic                            push_en;
    logic [CW-1:0]                   n_push;
    logic [CW-1:0]                   n_pop;

    fq_lane_compact #(.WIDTH(FETCH_WIDTH)) u_compact (
        .valid   (in_valid),
        .offset  (lane_off),
        .n_valid (lane_cnt)
    );

    // Ready is decided purely on registered occupancy, assuming all lanes
    // might be valid; a partial write is never performed.
    assign in_ready = (cnt <= CW'(DEPTH - FETCH_WIDTH));
    assign push_en  = in_ready && !flush && !rst;
    assign n_push   = push_en ? CW'(lane_cnt) : '0;
    // Over-pop is illegal; clamp so the pointers stay consistent anyway.
    assign n_pop    = (CW'(out_pop) > cnt) ? cnt : CW'(out_pop);
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(n_pop);
            tail <= tail + PW'(n_push);
            cnt  <= cnt + n_push - n_pop;
        end
    end

    // Storage is never cleared; pointers alone define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (push_en && in_valid[i]) begin
                mem[tail + PW'(lane_off[i])] <= in_entry[i];
            end
        end
    end

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_out
        assign out_valid[g] = (CW'(g) < cnt);
        assign out_entry[g] = mem[head + PW'(g)];
    end

    a_pop_le_count : assert property (@(posedge clk) disable iff (rst || flush)
        CW'(out_pop) <= cnt);
    a_no_push_not_ready : assert property (@(posedge clk) disable iff (rst)
        !in_ready |-> (n_push == '0));
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    import pipeline_types::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [1:0]      in_valid = '0;
    fq_entry_t [1:0] in_entry;
    logic            in_ready;
    logic [1:0]      out_valid;
    fq_entry_t [1:0] out_entry;
    logic [1:0]      out_pop = '0;
    logic [4:0]      count;

    int n_checks = 0;
    int n_fail   = 0;
    fq_entry_t exp_q[$];

    inst_fetch_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_entry  (in_entry),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .out_pop   (out_pop),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic fq_entry_t mk(input logic [31:0] pc);
        fq_entry_t e;
        e.pc              = pc;
        e.inst            = pc ^ 32'h1357_9bdf;
        e.is_branch       = pc[2];
        e.pre_taken       = pc[3];
        e.pre_target      = pc + 32'h40;
        e.is_exception    = pc[4];
        e.exception_cause = pc[10:4];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Applies one cycle of stimulus at a negedge, records what the queue
    // must contain after the coming posedge, and returns at the next negedge.
    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] pop, input logic fl);
        bit rdy;
        int np;
        in_valid    = v;
        in_entry[0] = mk(pc0);
        in_entry[1] = mk(pc1);
        out_pop     = pop;
        flush       = fl;
        rdy = (16 - exp_q.size()) >= 2;
        if (fl) begin
            exp_q.delete();
        end else begin
            np = int'(pop);
            if (np > exp_q.size()) np = exp_q.size();
            repeat (np) void'(exp_q.pop_front());
            if (rdy) begin
                if (v[0]) exp_q.push_back(mk(pc0));
                if (v[1]) exp_q.push_back(mk(pc1));
            end
        end
        @(negedge clk);
        in_valid = '0;
        out_pop  = '0;
        flush    = 1'b0;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    // Monitor: after each edge compare presented state with the scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            logic [1:0] ev;
            int sz;
            sz = exp_q.size();
            ev = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
            check("mon_count", 32'(count), 32'(sz));
            check("mon_out_valid", 32'(out_valid), 32'(ev));
            check("mon_in_ready", 32'(in_ready), 32'(sz <= 14));
            for (int i = 0; i < 2; i++) begin
                if (i < sz) begin
                    n_checks++;
                    if (out_entry[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL mon_entry[%0d]: got pc %0h inst %0h, expected pc %0h inst %0h",
                                 i, out_entry[i].pc, out_entry[i].inst, exp_q[i].pc, exp_q[i].inst);
                    end
                end
            end
        end
    end

    initial begin
        in_entry = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // reset then idle
        repeat (3) idle();
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // dual push then pop 2
        drive(2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'd0, 1'b0);
        check("dual_count", 32'(count), 32'd2);
        check("dual_out_valid", 32'(out_valid), 32'd3);
        check("dual_pc0", out_entry[0].pc, 32'h1c00_0000);
        check("dual_pc1", out_entry[1].pc, 32'h1c00_0004);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
        check("dual_pop_count", 32'(count), 32'd0);

        // sparse lane 1 only
        drive(2'b10, 32'h0bad_0000, 32'h1c00_0104, 2'd0, 1'b0);
        check("sparse_count", 32'(count), 32'd1);
        check("sparse_out_valid", 32'(out_valid), 32'd1);
        check("sparse_pc0", out_entry[0].pc, 32'h1c00_0104);
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);

        // fill to full, pushes while full are ignored
        for (int k = 0; k < 8; k++)
            drive(2'b11, 32'h1c00_1000 + 32'(8 * k), 32'h1c00_1004 + 32'(8 * k), 2'd0, 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(2'b11, 32'h0bad_0100, 32'h0bad_0104, 2'd0, 1'b0);
        check("full_ignore_count", 32'(count), 32'd16);
        check("full_ignore_pc0", out_entry[0].pc, 32'h1c00_1000);
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        check("pop1_count", 32'(count), 32'd15);
        check("pop1_in_ready", 32'(in_ready), 32'd0);
        check("pop1_pc0", out_entry[0].pc, 32'h1c00_1004);
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        check("pop2_count", 32'(count), 32'd14);
        check("pop2_in_ready", 32'(in_ready), 32'd1);
        repeat (7) drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
        check("drain_count", 32'(count), 32'd0);

        // steady push 2 / pop 2 across the wrap point
        drive(2'b11, 32'h1c00_2000, 32'h1c00_2004, 2'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            drive(2'b11, 32'h1c00_2000 + 32'(8 * k), 32'h1c00_2004 + 32'(8 * k), 2'd2, 1'b0);
            check("steady_count", 32'(count), 32'd2);
        end
        check("steady_last_pc0", out_entry[0].pc, 32'h1c00_20a0);
        check("steady_last_pc1", out_entry[1].pc, 32'h1c00_20a4);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);

        // flush at count 9 alongside push and pop
        for (int k = 0; k < 4; k++)
            drive(2'b11, 32'h1c00_3000 + 32'(8 * k), 32'h1c00_3004 + 32'(8 * k), 2'd0, 1'b0);
        drive(2'b01, 32'h1c00_3040, 32'h0bad_0300, 2'd0, 1'b0);
        check("preflush_count", 32'(count), 32'd9);
        drive(2'b11, 32'h0bad_0200, 32'h0bad_0204, 2'd2, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        drive(2'b11, 32'h1c00_4000, 32'h1c00_4004, 2'd0, 1'b0);
        check("postflush_count", 32'(count), 32'd2);
        check("postflush_pc0", out_entry[0].pc, 32'h1c00_4000);
        check("postflush_pc1", out_entry[1].pc, 32'h1c00_4004);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
        check("end_count", 32'(count), 32'd0);

        repeat (2) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
